// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage of the 5-stage 32-bit pipeline.
// Holds opcode and ALU-op encodings, the instruction field widths, and the
// is_writer helper that the forwarding and store-data logic use.
package execute_stage_pkg;

    localparam int XLEN = 32;
    localparam int RLEN = 5;

    // Major opcodes, IR[31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    // ALU operation codes, IR[6:2] for R-type
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    // True for opcodes that write a result to register rd.
    function automatic logic is_writer(input logic [4:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_ADDI) ||
               (opcode == OP_JAL)   || (opcode == OP_SETX) ||
               (opcode == OP_LW);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Purely combinational 32-bit ALU for the execute stage.
// Ports:
//   a, b    operands
//   op      ALU operation code (add/sub/and/or/sll/sra; others give 0)
//   shamt   shift amount for sll/sra
//   result  ALU result, wraps modulo 2^32
//   ne      a != b
//   lt      signed a < signed b
//   ovf     signed overflow of add/sub, 0 for every other op
module exec_alu
    import execute_stage_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    input  logic [4:0]      shamt,
    output logic [XLEN-1:0] result,
    output logic            ne,
    output logic            lt,
    output logic            ovf
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    assign ne = (a != b);
    assign lt = ($signed(a) < $signed(b));

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum;
                // Same-sign operands producing a different-sign sum.
                ovf    = ~(a[XLEN-1] ^ b[XLEN-1]) & (sum[XLEN-1] ^ a[XLEN-1]);
            end
            ALU_SUB: begin
                result = diff;
                // Different-sign operands where the result sign leaves A's.
                ovf    = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute (X) stage: operand forwarding, ALU, branch-target adder, and the
// X/M pipeline register.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   en               X/M register load enable (hold when low)
//   dx_ir, dx_pc     instruction and PC+1 from the D/X register
//   dx_a, dx_b       register-file values of rs and the B source
//   mw_ir, wb_data   instruction in W and the value it writes back
//   xm_ir, xm_o, xm_b  X/M register: instruction, ALU result, forwarded B
//   dmem_data        store data, bypassed from W when the store's rd is
//                    being written back
//   branch_target    dx_pc + sext(imm17)
//   alu_ne, alu_lt, alu_ovf  combinational ALU flags
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic [XLEN-1:0] dx_ir,
    input  logic [XLEN-1:0] dx_pc,
    input  logic [XLEN-1:0] dx_a,
    input  logic [XLEN-1:0] dx_b,
    input  logic [XLEN-1:0] mw_ir,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] xm_ir,
    output logic [XLEN-1:0] xm_o,
    output logic [XLEN-1:0] xm_b,
    output logic [XLEN-1:0] dmem_data,
    output logic [XLEN-1:0] branch_target,
    output logic            alu_ne,
    output logic            alu_lt,
    output logic            alu_ovf
);

    // Instruction fields of the instruction in X
    logic [4:0]      dx_op;
    logic [RLEN-1:0] dx_rd;
    logic [RLEN-1:0] dx_rs;
    logic [RLEN-1:0] dx_rt;
    logic [4:0]      dx_shamt;
    logic [4:0]      dx_aluop;
    logic [XLEN-1:0] imm_sext;

    assign dx_op    = dx_ir[31:27];
    assign dx_rd    = dx_ir[26:22];
    assign dx_rs    = dx_ir[21:17];
    assign dx_rt    = dx_ir[16:12];
    assign dx_shamt = dx_ir[11:7];
    assign dx_aluop = dx_ir[6:2];
    assign imm_sext = {{(XLEN-17){dx_ir[16]}}, dx_ir[16:0]};

    // Destinations of the older instructions in M and W
    logic [RLEN-1:0] xm_rd;
    logic [RLEN-1:0] mw_rd;
    logic            xm_writes;
    logic            mw_writes;

    assign xm_rd     = xm_ir[26:22];
    assign mw_rd     = mw_ir[26:22];
    // Writes to r0 are discarded, so an r0 destination never forwards.
    assign xm_writes = is_writer(xm_ir[31:27]) && (xm_rd != '0);
    assign mw_writes = is_writer(mw_ir[31:27]) && (mw_rd != '0);

    // Stores and branches compare/store the register named in rd.
    logic [RLEN-1:0] b_src;
    assign b_src = ((dx_op == OP_SW) || (dx_op == OP_BNE) || (dx_op == OP_BLT))
                   ? dx_rd : dx_rt;

    // Forwarding: X/M is younger than M/W, so it is checked first.
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    always_comb begin
        fwd_a = dx_a;
        if (xm_writes && (xm_rd == dx_rs))
            fwd_a = xm_o;
        else if (mw_writes && (mw_rd == dx_rs))
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = dx_b;
        if (xm_writes && (xm_rd == b_src))
            fwd_b = xm_o;
        else if (mw_writes && (mw_rd == b_src))
            fwd_b = wb_data;
    end

    // ALU operand B and operation select
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_op;

    always_comb begin
        alu_b  = fwd_b;
        alu_op = dx_aluop;
        case (dx_op)
            OP_ADDI, OP_SW, OP_LW: begin
                alu_b  = imm_sext;
                alu_op = ALU_ADD;
            end
            OP_BNE, OP_BLT: begin
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] alu_result;

    exec_alu u_alu (
        .a      (fwd_a),
        .b      (alu_b),
        .op     (alu_op),
        .shamt  (dx_shamt),
        .result (alu_result),
        .ne     (alu_ne),
        .lt     (alu_lt),
        .ovf    (alu_ovf)
    );

    assign branch_target = dx_pc + imm_sext;

    // X/M pipeline register; reset loads a NOP and overrides en.
    always_ff @(posedge clock) begin
        if (reset) begin
            xm_ir <= '0;
            xm_o  <= '0;
            xm_b  <= '0;
        end else if (en) begin
            xm_ir <= dx_ir;
            xm_o  <= alu_result;
            xm_b  <= fwd_b;
        end
    end

    // A store in M whose data register is being written back in W picks
    // up the W value (covers lw followed directly by sw of the same reg).
    assign dmem_data = ((xm_ir[31:27] == OP_SW) && mw_writes && (mw_rd == xm_rd))
                       ? wb_data : xm_b;

    // Bits that carry no meaning for this stage.
    logic unused_bits;
    assign unused_bits = ^{dx_ir[1:0], mw_ir[21:0]};

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage.
module tb_execute_stage;

    localparam logic [4:0] T_RTYPE = 5'b00000;
    localparam logic [4:0] T_ADDI  = 5'b00101;
    localparam logic [4:0] T_SW    = 5'b00111;
    localparam logic [4:0] T_LW    = 5'b01000;
    localparam logic [4:0] T_BNE   = 5'b00010;
    localparam logic [4:0] T_BLT   = 5'b00110;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] dx_ir, dx_pc, dx_a, dx_b, mw_ir, wb_data;
    logic [31:0] xm_ir, xm_o, xm_b, dmem_data, branch_target;
    logic        alu_ne, alu_lt, alu_ovf;

    int passed = 0;
    int total  = 0;

    execute_stage dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .dx_ir         (dx_ir),
        .dx_pc         (dx_pc),
        .dx_a          (dx_a),
        .dx_b          (dx_b),
        .mw_ir         (mw_ir),
        .wb_data       (wb_data),
        .xm_ir         (xm_ir),
        .xm_o          (xm_o),
        .xm_b          (xm_b),
        .dmem_data     (dmem_data),
        .branch_target (branch_target),
        .alu_ne        (alu_ne),
        .alu_lt        (alu_lt),
        .alu_ovf       (alu_ovf)
    );

    // clock/reset block
    always #5 clock = ~clock;

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] shamt,
                                           input logic [4:0] aluop);
        return {T_RTYPE, rd, rs, rt, shamt, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_type(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Advance one rising edge, then sit 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1;
        dx_ir = r_type(5'd3, 5'd0, 5'd0, 5'd0, 5'd0);
        dx_a = 32'd7; dx_b = 32'd9; dx_pc = 32'd0;
        mw_ir = 32'd0; wb_data = 32'd0;
        step(); step();
        total++; if (xm_ir !== 32'd0) $display("FAIL reset_xm_ir got=%h exp=%h", xm_ir, 32'd0); else passed++;
        total++; if (xm_o !== 32'd0) $display("FAIL reset_xm_o got=%h exp=%h", xm_o, 32'd0); else passed++;
        total++; if (xm_b !== 32'd0) $display("FAIL reset_xm_b got=%h exp=%h", xm_b, 32'd0); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_fwd_xm();
        // X/M := add r3 with result 7
        dx_ir = r_type(5'd3, 5'd0, 5'd0, 5'd0, 5'd0); dx_a = 32'd7; dx_b = 32'd0;
        step();
        total++; if (xm_o !== 32'd7) $display("FAIL fwd_xm_setup got=%h exp=%h", xm_o, 32'd7); else passed++;
        // add r4, r3, r2 : A from X/M (7), B = dx_b (5)
        dx_ir = r_type(5'd4, 5'd3, 5'd2, 5'd0, 5'd0); dx_a = 32'd100; dx_b = 32'd5;
        step();
        total++; if (xm_o !== 32'd12) $display("FAIL fwd_xm_result got=%h exp=%h", xm_o, 32'd12); else passed++;
        total++; if (xm_b !== 32'd5) $display("FAIL fwd_xm_b got=%h exp=%h", xm_b, 32'd5); else passed++;
        total++; if (xm_ir !== r_type(5'd4, 5'd3, 5'd2, 5'd0, 5'd0))
            $display("FAIL fwd_xm_ir got=%h exp=%h", xm_ir, r_type(5'd4, 5'd3, 5'd2, 5'd0, 5'd0)); else passed++;
        // X/M := add r0 (result 7); source r0 must not be forwarded
        dx_ir = r_type(5'd0, 5'd0, 5'd0, 5'd0, 5'd0); dx_a = 32'd7; dx_b = 32'd0;
        step();
        dx_ir = r_type(5'd4, 5'd0, 5'd2, 5'd0, 5'd0); dx_a = 32'd100; dx_b = 32'd5;
        step();
        total++; if (xm_o !== 32'd105) $display("FAIL fwd_r0 got=%h exp=%h", xm_o, 32'd105); else passed++;
    endtask

    task automatic test_priority();
        dx_ir = r_type(5'd3, 5'd0, 5'd0, 5'd0, 5'd0); dx_a = 32'd1; dx_b = 32'd0;
        step();
        // Both X/M and M/W write r3: X/M value 1 wins
        mw_ir = r_type(5'd3, 5'd0, 5'd0, 5'd0, 5'd0); wb_data = 32'd2;
        dx_ir = r_type(5'd4, 5'd3, 5'd0, 5'd0, 5'd0); dx_a = 32'd50;
        step();
        total++; if (xm_o !== 32'd1) $display("FAIL prio_xm got=%h exp=%h", xm_o, 32'd1); else passed++;
        // Only M/W matches now (X/M holds add r4): A = 2
        dx_ir = r_type(5'd5, 5'd3, 5'd0, 5'd0, 5'd0); dx_a = 32'd50;
        step();
        total++; if (xm_o !== 32'd2) $display("FAIL prio_mw got=%h exp=%h", xm_o, 32'd2); else passed++;
        // B operand from M/W: add r6, r0, r3 with wb 9
        wb_data = 32'd9;
        dx_ir = r_type(5'd6, 5'd0, 5'd3, 5'd0, 5'd0); dx_a = 32'd1; dx_b = 32'd100;
        step();
        total++; if (xm_o !== 32'd10) $display("FAIL fwd_b_mw_res got=%h exp=%h", xm_o, 32'd10); else passed++;
        total++; if (xm_b !== 32'd9) $display("FAIL fwd_b_mw_xmb got=%h exp=%h", xm_b, 32'd9); else passed++;
        mw_ir = 32'd0; wb_data = 32'd0;
    endtask

    task automatic test_overflow();
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd0, 5'd0); dx_a = 32'h7FFF_FFFF; dx_b = 32'd1;
        #1;
        total++; if (alu_ovf !== 1'b1) $display("FAIL ovf_add got=%b exp=%b", alu_ovf, 1'b1); else passed++;
        step();
        total++; if (xm_o !== 32'h8000_0000) $display("FAIL add_wrap got=%h exp=%h", xm_o, 32'h8000_0000); else passed++;
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd0, 5'd1); dx_a = 32'h8000_0000; dx_b = 32'd1;
        #1;
        total++; if (alu_ovf !== 1'b1) $display("FAIL ovf_sub got=%b exp=%b", alu_ovf, 1'b1); else passed++;
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd0, 5'd2);
        #1;
        total++; if (alu_ovf !== 1'b0) $display("FAIL ovf_and got=%b exp=%b", alu_ovf, 1'b0); else passed++;
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd0, 5'd3);
        #1;
        total++; if (alu_ovf !== 1'b0) $display("FAIL ovf_or got=%b exp=%b", alu_ovf, 1'b0); else passed++;
        step();
        total++; if (xm_o !== 32'h8000_0001) $display("FAIL or_result got=%h exp=%h", xm_o, 32'h8000_0001); else passed++;
    endtask

    task automatic test_shifts();
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd31, 5'd4); dx_a = 32'd1; dx_b = 32'd0;
        step();
        total++; if (xm_o !== 32'h8000_0000) $display("FAIL sll got=%h exp=%h", xm_o, 32'h8000_0000); else passed++;
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd4, 5'd5); dx_a = 32'h8000_0000;
        step();
        total++; if (xm_o !== 32'hF800_0000) $display("FAIL sra got=%h exp=%h", xm_o, 32'hF800_0000); else passed++;
    endtask

    task automatic test_imm_branch();
        dx_ir = i_type(T_ADDI, 5'd9, 5'd20, 17'h1FFFF); dx_a = 32'd10; dx_b = 32'd0;
        step();
        total++; if (xm_o !== 32'd9) $display("FAIL addi got=%h exp=%h", xm_o, 32'd9); else passed++;
        dx_ir = i_type(T_BNE, 5'd21, 5'd20, 17'h1FFFB); dx_pc = 32'd20; dx_a = 32'd3; dx_b = 32'd3;
        #1;
        total++; if (branch_target !== 32'd15) $display("FAIL branch_target got=%h exp=%h", branch_target, 32'd15); else passed++;
        total++; if (alu_ne !== 1'b0) $display("FAIL bne_eq got=%b exp=%b", alu_ne, 1'b0); else passed++;
        dx_b = 32'd4;
        #1;
        total++; if (alu_ne !== 1'b1) $display("FAIL bne_ne got=%b exp=%b", alu_ne, 1'b1); else passed++;
        dx_ir = i_type(T_BLT, 5'd21, 5'd20, 17'd0); dx_a = 32'hFFFF_FFFF; dx_b = 32'd2;
        #1;
        total++; if (alu_lt !== 1'b1) $display("FAIL blt_lt got=%b exp=%b", alu_lt, 1'b1); else passed++;
        // B source for blt is rd (r21), forwarded from W as 2: 5 < 2 false
        mw_ir = r_type(5'd21, 5'd0, 5'd0, 5'd0, 5'd0); wb_data = 32'd2;
        dx_a = 32'd5; dx_b = 32'd100;
        #1;
        total++; if (alu_lt !== 1'b0) $display("FAIL blt_fwd_rd got=%b exp=%b", alu_lt, 1'b0); else passed++;
        mw_ir = 32'd0; wb_data = 32'd0; dx_pc = 32'd0;
    endtask

    task automatic test_store_hold_reset();
        dx_ir = i_type(T_SW, 5'd5, 5'd20, 17'd4); dx_a = 32'd100; dx_b = 32'h55;
        step();
        total++; if (xm_o !== 32'd104) $display("FAIL sw_addr got=%h exp=%h", xm_o, 32'd104); else passed++;
        total++; if (xm_b !== 32'h55) $display("FAIL sw_xmb got=%h exp=%h", xm_b, 32'h55); else passed++;
        mw_ir = i_type(T_LW, 5'd5, 5'd0, 17'd0); wb_data = 32'hAB;
        #1;
        total++; if (dmem_data !== 32'hAB) $display("FAIL dmem_bypass got=%h exp=%h", dmem_data, 32'hAB); else passed++;
        mw_ir = i_type(T_LW, 5'd6, 5'd0, 17'd0);
        #1;
        total++; if (dmem_data !== 32'h55) $display("FAIL dmem_nobypass got=%h exp=%h", dmem_data, 32'h55); else passed++;
        // en low: register holds
        en = 1'b0;
        dx_ir = r_type(5'd1, 5'd20, 5'd21, 5'd0, 5'd0); dx_a = 32'd1; dx_b = 32'd1;
        step();
        total++; if (xm_o !== 32'd104) $display("FAIL hold_xm_o got=%h exp=%h", xm_o, 32'd104); else passed++;
        total++; if (xm_ir !== i_type(T_SW, 5'd5, 5'd20, 17'd4))
            $display("FAIL hold_xm_ir got=%h exp=%h", xm_ir, i_type(T_SW, 5'd5, 5'd20, 17'd4)); else passed++;
        // reset with en high clears
        en = 1'b1; reset = 1'b1;
        step();
        total++; if (xm_ir !== 32'd0) $display("FAIL rst2_xm_ir got=%h exp=%h", xm_ir, 32'd0); else passed++;
        total++; if (xm_o !== 32'd0) $display("FAIL rst2_xm_o got=%h exp=%h", xm_o, 32'd0); else passed++;
        total++; if (xm_b !== 32'd0) $display("FAIL rst2_xm_b got=%h exp=%h", xm_b, 32'd0); else passed++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_xm();
        test_priority();
        test_overflow();
        test_shifts();
        test_imm_branch();
        test_store_hold_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (X) stage of the 5-stage pipelined 32-bit processor.
- Contains operand forwarding (bypass) selection, a 32-bit ALU, and the branch-target adder.
- Ends in the X/M pipeline register.
- Sits between the D/X register (its inputs) and the memory stage (its outputs).

Parameters:
- None. Width is fixed at 32 bits; the register index is fixed at 5 bits.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the X/M register.
- en  in  1  X/M register load enable; when low, the register holds.
- dx_ir  in  32  instruction in X.
- dx_pc  in  32  PC+1 of the instruction in X.
- dx_a  in  32  register-file value of rs.
- dx_b  in  32  register-file value of the B source.
- mw_ir  in  32  instruction in the W stage.
- wb_data  in  32  value being written back in W.
- xm_ir  out  32  registered instruction.
- xm_o  out  32  registered ALU result, also the dmem address.
- xm_b  out  32  registered, already-forwarded B operand.
- dmem_data  out  32  store data to dmem.
- branch_target  out  32  combinational dx_pc + sext(imm17).
- alu_ne  out  1  combinational; A != B.
- alu_lt  out  1  combinational; A < B, signed.
- alu_ovf  out  1  combinational; signed overflow of add/sub.

Behaviour:
- Fields: opcode=IR[31:27], rd=IR[26:22], rs=IR[21:17], rt=IR[16:12], shamt=IR[11:7], aluop=IR[6:2], imm=IR[16:0].
- imm is sign-extended from bit 16.
- Writer opcodes: 00000 R-type, 00101 addi, 00011 jal, 10101 setx, 01000 lw. The destination of a writer is rd.
- A source is rs.
- B source is rd for sw(00111), bne(00010) and blt(00110); otherwise rt.
- Forwarding priority for A and for B, evaluated per operand:
  - 1st: xm_o, if xm_ir is a writer, its rd equals the source, and the source is not 0.
  - 2nd: wb_data, under the same test applied to mw_ir.
  - 3rd: dx_a / dx_b.
- Register 0 is never forwarded.
- Load-use hazards are excluded by the hazard unit. No special case exists for lw in X/M.
- ALU input B:
  - addi, sw, lw: sext(imm), ALU op forced to add.
  - bne, blt: forwarded B, ALU op forced to sub.
  - all other opcodes: forwarded B, ALU op = aluop.
- ALU ops:
  - 00000 add, 00001 sub, 00010 and, 00011 or.
  - 00100 sll by shamt, 00101 sra by shamt.
  - Any other code yields 0.
- alu_ne = (A != B). alu_lt = signed(A) < signed(B).
- alu_ovf:
  - add: set when both operands have the same sign and the sum sign differs.
  - sub: set when the operands differ in sign and the result sign differs from A.
  - all other ops: 0.
- Arithmetic wraps modulo 2^32.
- branch_target = dx_pc + sext(imm), modulo 2^32.
- X/M register:
  - On a rising edge with reset=1: xm_ir, xm_o and xm_b become 0 (a NOP); reset has priority over en.
  - Else on a rising edge with en=1: load dx_ir, the ALU result and the forwarded B.
  - Else: hold.
- dmem_data = wb_data when all hold: xm_ir is sw, mw_ir is a writer, mw rd equals xm rd, and xm rd is not 0. Otherwise dmem_data = xm_b.
- Simultaneous matches in X/M and M/W: X/M wins (youngest value).

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_JAL, OP_SETX;
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA;
  - an is_writer function.
- One sub-module, exec_alu, holds the pure-combinational ALU with its flags.
- Forwarding selection and the branch adder stay inline.

Test Plan:
- R-type add, forwarded from X/M: xm_ir = add r3, xm_o=7; dx_ir = add r4,r3,r2; dx_b=5. Result: after the edge, xm_o=12.
  - Repeat with xm rd=0: A uses dx_a.
- Priority: xm_ir and mw_ir both write r3 (xm_o=1, wb_data=2); dx_ir reads r3. A=1 is required.
  - With only the M/W match, A=2.
- Overflow: add with 0x7FFFFFFF + 1 gives xm_o=0x80000000 and alu_ovf=1.
  - sub with 0x80000000 - 1 gives alu_ovf=1.
  - and/or give alu_ovf=0.
- Shifts: sll of 1 by 31 gives 0x80000000. sra of 0x80000000 by 4 gives 0xF8000000.
- Immediate and branch:
  - addi with dx_a=10 and imm=0x1FFFF gives 9.
  - bne with dx_pc=20 and imm=-5 gives branch_target=15.
  - bne with A=3, B=3 gives alu_ne=0.
  - blt with A=-1, B=2 gives alu_lt=1.
- Store data and reset:
  - xm_ir=sw r5, mw_ir=lw r5, wb_data=0xAB gives dmem_data=0xAB.
  - With mw rd=6, dmem_data=xm_b.
  - reset=1 at an edge with en=1 gives all X/M outputs 0.
  - en=0 holds the outputs.
